// File: rtl/wshb_if.sv
// Wishbone classic bus bundle shared between a master and a slave.
// Clock and reset travel with the bus so a single port carries everything.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack;

   modport master (
      input  clk, rst, ack, dat_sm,
      output cyc, stb, we, sel, adr, dat_ms
   );

   modport slave (
      input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
      output ack, dat_sm
   );
endinterface

// File: rtl/wb_seq_reader.sv
// Wishbone master that reads a block of consecutive 32-bit words and streams
// them out in address order through a first-word-fall-through FIFO.
//
// state  | meaning
// S_IDLE | waiting for start
// S_READ | issuing single reads until the word count reaches zero
// S_DONE | one-cycle completion pulse, then back to idle
module wb_seq_reader #(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   wshb_if.master            wb_m,
   input  logic              start,
   input  logic [31:0]       base_adr,
   input  logic [LEN_W-1:0]  nwords,
   output logic              busy,
   output logic              done,
   output logic [31:0]       out_dat,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

   state_t             state_q;
   logic               stb_q;
   logic               busy_q;
   logic               done_q;
   logic [31:0]        adr_q;
   logic [LEN_W-1:0]   rem_q;
   logic [LEN_W-1:0]   rem_d;
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic [CW-1:0]      count_d;
   logic [31:0]        mem_q [FIFO_DEPTH];
   logic               xfer;
   logic               pop;
   logic               room_d;

   assign xfer      = stb_q & wb_m.ack;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   assign count_d   = count_q + CW'(xfer) - CW'(pop);
   assign rem_d     = rem_q - LEN_W'(xfer);
   // Room is judged on next cycle's occupancy, so a same-cycle pop frees a slot.
   assign room_d    = (count_d < DEPTH_C);

   assign wb_m.cyc    = stb_q;
   assign wb_m.stb    = stb_q;
   assign wb_m.we     = 1'b0;
   assign wb_m.sel    = 4'hF;
   assign wb_m.dat_ms = 32'h0;
   assign wb_m.adr    = adr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign out_dat     = mem_q[rd_ptr_q];

   always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
      if (wb_m.rst) begin
         state_q <= S_IDLE;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         adr_q   <= 32'h0;
         rem_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  busy_q <= 1'b1;
                  if (nwords != '0) begin
                     state_q <= S_READ;
                     adr_q   <= {base_adr[31:2], 2'b00};
                     rem_q   <= nwords;
                     stb_q   <= room_d;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (xfer) begin
                  adr_q <= adr_q + 32'd4;
                  rem_q <= rem_d;
                  if (rem_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     stb_q   <= 1'b0;
                  end else begin
                     stb_q <= room_d;
                  end
               end else if (!stb_q) begin
                  stb_q <= room_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               stb_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
      if (wb_m.rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (xfer) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge wb_m.clk) begin
      if (xfer) mem_q[wr_ptr_q] <= wb_m.dat_sm;
   end
endmodule

// File: doc/wb_seq_reader.md
# wb_seq_reader

Wishbone master that reads a contiguous block of 32-bit words starting at a programmed byte address and delivers them, in address order, on a valid/ready stream. It is the initiator counterpart to the team's Wishbone slave memories (BlockRAM, SDRAM controller), and feeds consumers such as the display pipeline. An internal FIFO decouples bus acknowledges from stream back-pressure.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: stream FIFO depth in words. Must be a power of 2 and at least 2.
- `LEN_W`, default 16: width of the word-count input.

Ports:
- `wb_m.clk`, input, 1: system clock, carried in `wshb_if`. All logic is on the rising edge.
- `wb_m.rst`, input, 1: reset, carried in `wshb_if`. Asynchronous, active-high.
- `wb_m`, master modport of `wshb_if`:
  - drives `cyc`, `stb`, `we`, `sel[3:0]`, `adr[31:0]`, `dat_ms[31:0]`.
  - samples `ack` and `dat_sm[31:0]`.
- `start`, input, 1: one-cycle request to begin a block read.
- `base_adr`, input, 32: byte address of the first word. Bits [1:0] are forced to 0.
- `nwords`, input, LEN_W: number of words to read.
- `busy`, output, 1: a block read is in progress.
- `done`, output, 1: one-cycle pulse when the last word has been acknowledged.
- `out_dat`, output, 32: head-of-FIFO word.
- `out_valid`, output, 1: `out_dat` is valid.
- `out_ready`, input, 1: the consumer accepts a word when `out_valid & out_ready`.

## Operation
- Fixed bus outputs: `we`=0, `sel`=4'hF, `dat_ms`=0. Transfers are classic single reads only.
- State machine:
  - IDLE to READ: on `start` with `nwords`≠0. Latch `adr`←{`base_adr`[31:2],2'b00} and `remaining`←`nwords`.
  - IDLE to DONE: on `start` with `nwords`=0. No bus activity.
  - READ to DONE: on the ack that makes `remaining`=0.
  - DONE to IDLE: unconditionally, after one cycle. `done`=1 only in DONE.
- `busy` is 1 in READ and DONE, and 0 in IDLE.
- `start` is ignored outside IDLE.
- `cyc` equals `stb`.
- Raising `stb`: only in READ, and only when FIFO count < FIFO_DEPTH.
- Holding `stb`: once raised, `stb` stays high until `ack`. It never drops before `ack`.
- Each cycle with `stb & ack` is one transfer:
  - `dat_sm` is pushed into the FIFO.
  - `adr` += 4, wrapping modulo 2^32.
  - `remaining` -= 1.
- After an ack, `stb` stays high next cycle iff `remaining_next`>0 and `count_next`<FIFO_DEPTH. `count_next` includes any same-cycle pop.
- At most one transfer is outstanding, so the FIFO never overflows. An ack while the FIFO is full is a design error; the bench asserts it never happens.
- The FIFO is first-word-fall-through.
  - `out_valid` = (count≠0).
  - A pop on `out_valid & out_ready`; a push on ack. Both may occur in the same cycle, and count is then unchanged.
- The FIFO is not flushed by `start`. Words from the previous block still drain first, in order.
- `ack` while `stb`=0 is ignored.

## Timing
- Reset values: `cyc`=`stb`=0, `adr`=0, `busy`=0, `done`=0, `out_valid`=0. FIFO is empty, state is IDLE.
- Reset mid-transfer: all of the above apply immediately (asynchronously). The pending transfer and the FIFO contents are discarded.
- Sequence for `start` in cycle 0:
  - cycle 1: `busy`=1, `cyc`=`stb`=1, `adr`=base.
  - With a 1-cycle-ack slave (BlockRAM), `ack` arrives in cycle 2.
  - The word shows on `out_dat` with `out_valid`=1 in cycle 3.
- Ack to `out_valid`: 1 cycle.
- `done` is high in the cycle after the last ack. `busy` falls the cycle after `done`.
- Back-to-back operation: `stb` stays continuously high. Against the BlockRAM, which acks every other cycle, throughput is 1 word per 2 cycles.
- When the FIFO is full, `stb` is low. It rises the cycle after the pop that frees a slot.

## Test plan
- Reset and idle: assert `rst` asynchronously, between clock edges -> all outputs are 0 immediately. Hold for 20 cycles with no `start` -> `cyc` stays 0.
- Basic read: BlockRAM preloaded with mem[k]=32'hA000_0000+k; `base_adr`=32'h10, `nwords`=8, `out_ready`=1 -> stream gives A000_0004..A000_000B in order. Exactly 8 acks, `done` pulses once, addresses go 0x10..0x2C.
- Back-pressure: `nwords`=40, FIFO_DEPTH=16, `out_ready`=0 for 100 cycles then 1 -> `stb` drops after 16 acks, never drops before an ack, no overflow, all 40 words in order.
- Zero length and ignored start: `nwords`=0 -> `done` at cycle 1, no `cyc`. A `start` pulse during READ -> ignored, word count unchanged.
- Reset mid-block: assert `rst` after 3 of 10 acks -> `stb`/`cyc`/`out_valid` go to 0 at once. A new `start`, base 0, `nwords`=2 -> exactly 2 fresh words, none stale.
- Address wrap and random ack delay: `base_adr`=32'hFFFF_FFF8, `nwords`=4, slave acking after random 0-5 wait cycles -> `adr` is FFFF_FFF8, FFFF_FFFC, 0, 4, and data stays correct.
